// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types and helpers for the XOR cipher stream blocks
package xor_cipher_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2
  } state_e;

  // Even-parity bit of a word (zero-extend narrower words into v).
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/xor_decipher_stream_if.sv
// rtl/xor_decipher_stream_if.sv - key, ciphertext and plaintext bus (XOR_PARITY_CHECK_EN adds ct_par/par_err)
interface xor_decipher_stream_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              key_load;
  logic [DATA_W-1:0] key_in;
  logic              key_ack;
  logic              key_nack;
  logic              ct_valid;
  logic              ct_ready;
  logic [DATA_W-1:0] ct_data;
  logic              ct_last;
  logic              pt_valid;
  logic              pt_ready;
  logic [DATA_W-1:0] pt_data;
  logic              pt_last;
  logic [CNT_W-1:0]  byte_cnt;
  logic              frame_done;
`ifdef XOR_PARITY_CHECK_EN
  logic              ct_par;
  logic              par_err;
`endif

  modport master (
    output key_load, key_in, ct_valid, ct_data, ct_last, pt_ready,
    input  key_ack, key_nack, ct_ready, pt_valid, pt_data, pt_last, byte_cnt, frame_done
`ifdef XOR_PARITY_CHECK_EN
    , output ct_par
    , input  par_err
`endif
  );

  modport slave (
    input  key_load, key_in, ct_valid, ct_data, ct_last, pt_ready,
    output key_ack, key_nack, ct_ready, pt_valid, pt_data, pt_last, byte_cnt, frame_done
`ifdef XOR_PARITY_CHECK_EN
    , input  ct_par
    , output par_err
`endif
  );

endinterface

// File: rtl/xor_stream_fifo.sv
// rtl/xor_stream_fifo.sv - small register FIFO with valid/ready on both sides
module xor_stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign in_tready  = (count_q != FULL_CNT);
  assign out_tvalid = (count_q != '0);
  // Data is forced to zero while empty so the output reads 0 straight out of reset.
  assign out_tdata  = out_tvalid ? mem_q[rd_ptr_q] : '0;
  assign push       = in_tvalid & in_tready;
  assign pop        = out_tvalid & out_tready;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_tdata;
  end

endmodule

// File: rtl/xor_decipher_stream.sv
// rtl/xor_decipher_stream.sv - streaming XOR decipher with framed input and buffered output (option: XOR_PARITY_CHECK_EN)
module xor_decipher_stream
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  xor_decipher_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d, cnt_base;
  logic              key_ack_q, key_nack_q, key_block_q, frame_done_q;
  logic              ct_ready_c, ct_fire, key_accept;
  logic              fifo_in_ready, fifo_out_valid;
  logic [DATA_W:0]   fifo_in, fifo_out;
  logic [DATA_W-1:0] plain;

  // The key used is the one held at acceptance time; later key changes never touch buffered words.
  assign plain   = bus.ct_data ^ key_q;
  assign fifo_in = {bus.ct_last, plain};

  // Ready depends only on state, buffer space and the post-key-load bubble, never on ct_valid.
  assign ct_ready_c = (state_q != S_NOKEY) && fifo_in_ready && !key_block_q;
  assign ct_fire    = bus.ct_valid && ct_ready_c;

  xor_stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .in_tdata   (fifo_in),
    .in_tvalid  (ct_fire),
    .in_tready  (fifo_in_ready),
    .out_tdata  (fifo_out),
    .out_tvalid (fifo_out_valid),
    .out_tready (bus.pt_ready)
  );

  assign bus.ct_ready   = ct_ready_c;
  assign bus.pt_valid   = fifo_out_valid;
  assign bus.pt_data    = fifo_out[DATA_W-1:0];
  assign bus.pt_last    = fifo_out[DATA_W];
  assign bus.key_ack    = key_ack_q;
  assign bus.key_nack   = key_nack_q;
  assign bus.byte_cnt   = byte_cnt_q;
  assign bus.frame_done = frame_done_q;

  // Frame FSM next state and key-load arbitration; a coinciding ct transfer beats a key load.
  always_comb begin
    state_d    = state_q;
    key_accept = 1'b0;
    case (state_q)
      S_NOKEY: begin
        if (bus.key_load) begin
          key_accept = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        key_accept = bus.key_load && !fifo_out_valid && !ct_fire;
        if (ct_fire && !bus.ct_last) state_d = S_FRAME;
      end
      S_FRAME: begin
        if (ct_fire && bus.ct_last) state_d = S_IDLE;
      end
      default: state_d = S_NOKEY;
    endcase
  end

  // Key and counter next-state; a pending end-of-frame clear and a new word combine to count 1.
  always_comb begin
    key_d      = key_accept ? bus.key_in : key_q;
    cnt_base   = frame_done_q ? '0 : byte_cnt_q;
    byte_cnt_d = cnt_base;
    if (ct_fire) byte_cnt_d = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_ONE;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_NOKEY;
      key_q        <= '0;
      byte_cnt_q   <= '0;
      key_ack_q    <= 1'b0;
      key_nack_q   <= 1'b0;
      key_block_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      byte_cnt_q   <= byte_cnt_d;
      key_ack_q    <= key_accept;
      key_nack_q   <= bus.key_load && !key_accept;
      key_block_q  <= key_accept;
      frame_done_q <= ct_fire && bus.ct_last;
    end
  end

`ifdef XOR_PARITY_CHECK_EN
  logic par_err_q, par_err_d;

  assign bus.par_err = par_err_q;

  // Sticky parity error: set on a bad accepted word, cleared only by an accepted key load.
  always_comb begin
    par_err_d = par_err_q;
    if (key_accept) par_err_d = 1'b0;
    else if (ct_fire && (even_par(64'(plain)) != bus.ct_par)) par_err_d = 1'b1;
  end

  // Parity error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= par_err_d;
  end
`endif

endmodule

// File: tb/tb_xor_decipher_stream.sv
// tb/tb_xor_decipher_stream.sv - randomized scoreboard bench for xor_decipher_stream
module tb_xor_decipher_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xor_decipher_stream_if #(.DATA_W(8), .CNT_W(16)) bus ();

  xor_decipher_stream #(.DATA_W(8), .CNT_W(16), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  logic [7:0]  key_m  = 8'h00;
  logic [15:0] cnt_m  = 16'd0;
  bit          perr_m = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ^(d ^ key_m);
  endfunction

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
  initial begin
    bus.pt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.pt_ready = 1'b1;
        1:       bus.pt_ready = 1'($urandom_range(0, 1));
        default: bus.pt_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every plaintext transfer and checks stall stability.
  initial begin
    logic [8:0] prev_word, e;
    bit prev_stall;
    prev_stall = 0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst) prev_stall = 0;
      else begin
        if (prev_stall) begin
          chk("pt_hold_valid", bus.pt_valid, 1);
          chk("pt_hold_word", {bus.pt_last, bus.pt_data}, prev_word);
        end
        if (bus.pt_valid && bus.pt_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pt_unexpected: got %0h expected none at %0t", {bus.pt_last, bus.pt_data}, $time);
          end else begin
            e = exp_q.pop_front();
            chk("pt_word", {bus.pt_last, bus.pt_data}, e);
          end
        end
        prev_stall = bus.pt_valid && !bus.pt_ready;
        prev_word  = {bus.pt_last, bus.pt_data};
      end
    end
  end

  // Offer one ciphertext word until accepted; optionally raise key_load in the same cycle.
  task automatic send_word(input logic [7:0] d, input logic l, input logic p, input bit kl);
    int n;
    bit done;
    bus.ct_data  = d;
    bus.ct_last  = l;
`ifdef XOR_PARITY_CHECK_EN
    bus.ct_par   = p;
`endif
    bus.ct_valid = 1'b1;
    if (kl) begin
      bus.key_in   = 8'h77;
      bus.key_load = 1'b1;
    end
    done = 0;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      if (bus.ct_ready) begin
        exp_q.push_back({l, d ^ key_m});
        if (p != good_par(d)) perr_m = 1'b1;
        done = 1;
      end
      @(posedge clk);
      #1;
      bus.key_load = 1'b0;
      n++;
    end
    bus.ct_valid = 1'b0;
    if (!done) chk("ct_accept_timeout", 0, 1);
    else begin
      cnt_m = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 16'd1;
      chk("byte_cnt", bus.byte_cnt, cnt_m);
      chk("frame_done", bus.frame_done, l);
      if (kl) begin
        chk("coincide_nack", bus.key_nack, 1);
        chk("coincide_ack", bus.key_ack, 0);
      end
`ifdef XOR_PARITY_CHECK_EN
      chk("par_err", bus.par_err, perr_m);
`endif
      if (l) cnt_m = 16'd0;
    end
  endtask

  task automatic sw(input logic [7:0] d, input logic l);
    send_word(d, l, good_par(d), 0);
  endtask

  task automatic do_key(input logic [7:0] k, input bit exp_ack);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    chk("key_ack", bus.key_ack, exp_ack);
    chk("key_nack", bus.key_nack, !exp_ack);
    if (exp_ack) begin
      key_m  = k;
      perr_m = 1'b0;
      chk("ct_ready_after_key", bus.ct_ready, 0);
    end
`ifdef XOR_PARITY_CHECK_EN
    chk("par_err_key", bus.par_err, perr_m);
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    logic [7:0] d;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.ct_valid = 1'b0;
    bus.ct_data  = '0;
    bus.ct_last  = 1'b0;
`ifdef XOR_PARITY_CHECK_EN
    bus.ct_par   = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("rst_pt_valid", bus.pt_valid, 0);
    chk("rst_ct_ready", bus.ct_ready, 0);
    chk("rst_pt_data", bus.pt_data, 0);
    chk("rst_key_ack", bus.key_ack, 0);
    chk("rst_byte_cnt", bus.byte_cnt, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // No key yet: ciphertext must be refused.
    bus.ct_valid = 1'b1;
    bus.ct_data  = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("nokey_ct_ready", bus.ct_ready, 0);
      chk("nokey_pt_valid", bus.pt_valid, 0);
    end
    @(posedge clk);
    #1;
    bus.ct_valid = 1'b0;

    do_key(8'h5A, 1);

    // Basic frame with first-word latency and single frame_done pulse.
    sw(8'hFF, 0);
    chk("latency_pt_valid", bus.pt_valid, 1);
    chk("latency_pt_data", bus.pt_data, 8'hA5);
    sw(8'h5A, 0);
    sw(8'h00, 1);
    @(posedge clk);
    #1;
    chk("frame_done_once", bus.frame_done, 0);
    chk("byte_cnt_cleared", bus.byte_cnt, 0);
    drain();

    // Downstream stall: buffer fills after two words, ct_ready drops.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    sw(8'h10, 0);
    sw(8'h11, 0);
    bus.ct_data  = 8'h12;
    bus.ct_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ct_ready", bus.ct_ready, 0);
      chk("full_pt_valid", bus.pt_valid, 1);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    sw(8'h12, 0);
    sw(8'h13, 0);
    sw(8'h14, 1);
    drain();

    // Mid-frame key load is refused; old key stays in use.
    sw(8'h21, 0);
    do_key(8'h11, 0);
    sw(8'h22, 0);
    sw(8'h23, 1);
    drain();
    do_key(8'h11, 1);
    sw(8'h31, 0);
    sw(8'h32, 1);
    drain();

    // Key load coinciding with an idle-state transfer loses to the transfer.
    send_word(8'h44, 1, good_par(8'h44), 1);
    drain();

    // Randomized frames with random downstream pressure and key changes.
    for (int f = 0; f < 30; f++) begin
      rdy_mode = $urandom_range(0, 1);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        d = 8'($urandom);
        send_word(d, (i == len - 1), good_par(d) ^ ($urandom_range(0, 9) == 0), 0);
        if (i == 0 && len > 1 && $urandom_range(0, 3) == 0) do_key(8'($urandom), 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        drain();
        do_key(8'($urandom), 1);
      end
    end
    rdy_mode = 0;
    drain();

`ifdef XOR_PARITY_CHECK_EN
    do_key(8'h0F, 1);
    send_word(8'h0E, 1, 1'b0, 0);
    chk("par_err_set", bus.par_err, 1);
    sw(8'h30, 1);
    chk("par_err_sticky", bus.par_err, 1);
    drain();
    do_key(8'h0F, 1);
    chk("par_err_cleared", bus.par_err, 0);
`endif

    // Asynchronous reset with one word buffered: it must never appear.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    sw(8'h55, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pt_valid", bus.pt_valid, 0);
    chk("arst_pt_data", bus.pt_data, 0);
    chk("arst_pt_last", bus.pt_last, 0);
    chk("arst_ct_ready", bus.ct_ready, 0);
    chk("arst_byte_cnt", bus.byte_cnt, 0);
    exp_q.delete();
    key_m  = 8'h00;
    cnt_m  = 16'd0;
    perr_m = 1'b0;
`ifdef XOR_PARITY_CHECK_EN
    chk("arst_par_err", bus.par_err, 0);
`endif
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    bus.ct_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_nokey_ct_ready", bus.ct_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.ct_valid = 1'b0;
    do_key(8'hC3, 1);
    for (int i = 0; i < 4; i++) sw(8'($urandom), (i == 3));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_decipher_stream.md
Name: xor_decipher_stream

Overview:
- Streaming receive-side counterpart of the team's XOR cipher block: recovers plaintext bytes as pt = ct XOR key.
- Ciphertext arrives on a valid/ready stream with frame delimiting; plaintext leaves through a registered output buffer.
- Keys are loaded through a sideband port and are only accepted between frames.
- Sits between the link receiver and downstream consumers; also serves as the loopback checker for the encrypt path.

Parameters:
DATA_W, 8, width of the ciphertext, plaintext and key words
CNT_W, 16, width of the per-frame byte counter
FIFO_DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-low reset
key_load  input  1  request to load key_in (single-cycle pulse)
key_in  input  DATA_W  new key value
key_ack  output  1  1-cycle pulse: key accepted
key_nack  output  1  1-cycle pulse: key rejected (mid-frame or buffer not empty)
ct_valid  input  1  ciphertext word valid
ct_ready  output  1  block can accept a ciphertext word
ct_data  input  DATA_W  ciphertext word
ct_last  input  1  final word of frame
pt_valid  output  1  plaintext word valid
pt_ready  input  1  downstream accepts a plaintext word
pt_data  output  DATA_W  plaintext word
pt_last  output  1  final word of frame
byte_cnt  output  CNT_W  words accepted in the current frame
frame_done  output  1  1-cycle pulse when ct_last is accepted

Behaviour:
- Reset (rst=0, asynchronous) sets every output to 0, clears the key register, empties the FIFO and enters S_NOKEY.
- States:
  - S_NOKEY: ct_ready=0. A key_load moves the FSM to S_IDLE and pulses key_ack next cycle.
  - S_IDLE: between frames. ct_ready = !fifo_full. Accepting a word moves to S_FRAME, unless that word has ct_last=1, in which case the FSM stays in S_IDLE.
  - S_FRAME: ct_ready = !fifo_full. Accepting a word with ct_last=1 returns to S_IDLE.
- Handshake:
  - A transfer happens when valid & ready are both 1 on a rising clk.
  - ct_ready does not depend combinationally on ct_valid.
  - pt_data/pt_last stay stable while pt_valid=1 & pt_ready=0.
- Latency:
  - An accepted word appears on pt_* on the next cycle when the FIFO was empty.
  - Throughput is 1 word/cycle when pt_ready=1 continuously.
- Arithmetic: pt_data = ct_data XOR key_reg, where key_reg is the value at the time of acceptance. No truncation (all words are DATA_W).
- byte_cnt:
  - Increments on each accepted word and saturates at 2^CNT_W-1.
  - Resets to 0 on the cycle after ct_last is accepted, so a new frame counts from 1.
- frame_done pulses on the cycle after ct_last is accepted.
- key_load rules:
  - Accepted only in S_NOKEY, or in S_IDLE with the FIFO empty and no ct transfer in that cycle.
  - Otherwise key_nack pulses and key_reg is unchanged.
  - If key_load and a ct transfer coincide in S_IDLE, the transfer wins and the key is nacked.
  - ct_ready is forced to 0 in the cycle after an accepted key_load.
- FIFO:
  - Full: ct_ready=0.
  - Empty: pt_valid=0.
  - Simultaneous push and pop when full is not possible, because ct_ready is already 0.
  - Simultaneous push and pop when non-empty leaves the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: all in-flight words are discarded, no pt_last is emitted, and the key is lost.

Optional Feature:
- Macro: XOR_PARITY_CHECK_EN.
- With the macro defined:
  - Adds input ct_par (1 bit): even parity over plaintext+par, as generated by the encrypt side.
  - Adds output par_err, a sticky flag.
  - On acceptance, ^(ct_data XOR key_reg) != ct_par sets par_err.
  - par_err clears only on reset or an accepted key_load.
  - Data is still forwarded.
- Without the macro: the ports do not exist and there is no parity logic.

Decomposition:
- Shared package xor_cipher_pkg: DATA_W default, the state enum (S_NOKEY, S_IDLE, S_FRAME), and a parity function.
- One natural sub-module: xor_stream_fifo (parameterised DATA_W+1 wide, FIFO_DEPTH deep, valid/ready on both sides).

Test Plan:
- Reset, then ct_valid=1 without a key -> ct_ready=0, pt_valid=0; after key_load key_in=0x5A -> key_ack next cycle.
- Key 0x5A, frame ct 0xFF,0x5A,0x00(last) with pt_ready=1 -> pt 0xA5,0x00,0x5A one cycle later; pt_last on the third word; byte_cnt 1,2,3; frame_done pulses once.
- pt_ready=0 for 4 cycles during a 5-word frame -> ct_ready drops after 2 accepts; pt_data stable; no loss or duplication after release.
- key_load 0x11 mid-frame (S_FRAME) -> key_nack; following words still decrypted with 0x5A; key_load after frame end with FIFO empty -> key_ack and new key used.
- rst asserted asynchronously mid-frame with 1 word buffered -> outputs 0 immediately; S_NOKEY; buffered word never appears.
- XOR_PARITY_CHECK_EN: key 0x0F, ct 0x0E with ct_par=0 (plaintext 0x01 has odd parity) -> par_err=1 and stays set; accepted key_load clears it.
